// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: two one-entry holding registers (ALU, load/store) share
// the register file's single write port, issuing in age order with a RAW scoreboard.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [3:0]  alu_addr,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [3:0]  mem_addr,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic        rf_wen,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [15:0] busy
);

  logic        r_alu_v;
  logic [3:0]  r_alu_addr;
  logic [31:0] r_alu_data;
  logic        r_mem_v;
  logic [3:0]  r_mem_addr;
  logic [31:0] r_mem_data;
  logic        r_alu_older;
  logic        r_tie;
  logic        r_last_mem;
  logic        r_wen;
  logic [3:0]  r_waddr;
  logic [31:0] r_wdata;

  logic        w_grant_alu;
  logic        w_grant_mem;
  logic        w_alu_load;
  logic        w_mem_load;
  logic        w_alu_next_v;
  logic        w_mem_next_v;
  logic [15:0] w_busy;

  // Entries loaded on the same edge have no age order; round-robin breaks the tie.
  always_comb begin
    w_grant_alu = 1'b0;
    w_grant_mem = 1'b0;
    if (r_alu_v && !r_mem_v) begin
      w_grant_alu = 1'b1;
    end else if (!r_alu_v && r_mem_v) begin
      w_grant_mem = 1'b1;
    end else if (r_alu_v && r_mem_v) begin
      if (r_tie) begin
        w_grant_alu = r_last_mem;
        w_grant_mem = !r_last_mem;
      end else begin
        w_grant_alu = r_alu_older;
        w_grant_mem = !r_alu_older;
      end
    end
  end

  assign alu_ready    = !r_alu_v | w_grant_alu;
  assign mem_ready    = !r_mem_v | w_grant_mem;
  assign w_alu_load   = alu_valid & alu_ready;
  assign w_mem_load   = mem_valid & mem_ready;
  assign w_alu_next_v = w_alu_load | (r_alu_v & !w_grant_alu);
  assign w_mem_next_v = w_mem_load | (r_mem_v & !w_grant_mem);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_v     <= 1'b0;
      r_alu_addr  <= 4'd0;
      r_alu_data  <= 32'd0;
      r_mem_v     <= 1'b0;
      r_mem_addr  <= 4'd0;
      r_mem_data  <= 32'd0;
      r_alu_older <= 1'b0;
      r_tie       <= 1'b0;
      r_last_mem  <= 1'b1;
      r_wen       <= 1'b0;
      r_waddr     <= 4'd0;
      r_wdata     <= 32'd0;
    end else begin
      r_alu_v <= w_alu_next_v;
      r_mem_v <= w_mem_next_v;
      if (w_alu_load) begin
        r_alu_addr <= alu_addr;
        r_alu_data <= alu_data;
      end
      if (w_mem_load) begin
        r_mem_addr <= mem_addr;
        r_mem_data <= mem_data;
      end

      if (w_grant_alu) begin
        r_wen   <= 1'b1;
        r_waddr <= r_alu_addr;
        r_wdata <= r_alu_data;
      end else if (w_grant_mem) begin
        r_wen   <= 1'b1;
        r_waddr <= r_mem_addr;
        r_wdata <= r_mem_data;
      end else begin
        r_wen <= 1'b0;
      end
      if (w_grant_alu || w_grant_mem) begin
        r_last_mem <= w_grant_mem;
      end

      // A loading entry becomes the younger one if the other entry survives this edge.
      if (w_alu_load && w_mem_load) begin
        r_tie <= 1'b1;
      end else if (w_alu_load && w_mem_next_v) begin
        r_tie       <= 1'b0;
        r_alu_older <= 1'b0;
      end else if (w_mem_load && w_alu_next_v) begin
        r_tie       <= 1'b0;
        r_alu_older <= 1'b1;
      end
    end
  end

  always_comb begin
    w_busy = 16'd0;
    if (r_alu_v) w_busy[r_alu_addr] = 1'b1;
    if (r_mem_v) w_busy[r_mem_addr] = 1'b1;
    if (r_wen)   w_busy[r_waddr]    = 1'b1;
  end

  assign rf_wen   = r_wen;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;
  assign busy     = w_busy;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: inputs driven and outputs sampled on the
// falling edge, expected values written out by hand per scenario.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_addr = 4'd0;
  logic [31:0] alu_data = 32'd0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [3:0]  mem_addr = 4'd0;
  logic [31:0] mem_data = 32'd0;
  logic        mem_ready;
  logic        rf_wen;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [15:0] busy;

  int compared = 0;
  int mismatched = 0;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if ({rf_wen, rf_waddr, rf_wdata} !== 37'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_rf: got %h expected %h", {rf_wen, rf_waddr, rf_wdata}, 37'h0);
    end
    compared++;
    if (busy !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL reset_busy: got %h expected 0000", busy);
    end
    compared++;
    if ({alu_ready, mem_ready} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b expected 11", {alu_ready, mem_ready});
    end
  endtask

  task automatic test_single_alu();
    do_reset();
    alu_valid = 1'b1;
    alu_addr  = 4'd5;
    alu_data  = 32'hDEADBEEF;
    @(negedge clk);
    alu_valid = 1'b0;
    compared++;
    if ({rf_wen, busy} !== {1'b0, 16'h0020}) begin
      mismatched++;
      $display("[TB] FAIL single_held: got wen/busy %h expected %h", {rf_wen, busy}, {1'b0, 16'h0020});
    end
    @(negedge clk);
    compared++;
    if ({rf_wen, rf_waddr, rf_wdata, busy} !== {1'b1, 4'd5, 32'hDEADBEEF, 16'h0020}) begin
      mismatched++;
      $display("[TB] FAIL single_write: got %h expected %h", {rf_wen, rf_waddr, rf_wdata, busy},
               {1'b1, 4'd5, 32'hDEADBEEF, 16'h0020});
    end
    @(negedge clk);
    compared++;
    if ({rf_wen, rf_waddr, rf_wdata, busy} !== {1'b0, 4'd5, 32'hDEADBEEF, 16'h0000}) begin
      mismatched++;
      $display("[TB] FAIL single_done: got %h expected %h", {rf_wen, rf_waddr, rf_wdata, busy},
               {1'b0, 4'd5, 32'hDEADBEEF, 16'h0000});
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 32'h11;
    mem_valid = 1'b1; mem_addr = 4'd4; mem_data = 32'h22;
    @(negedge clk);
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    compared++;
    if ({alu_ready, mem_ready, busy} !== {2'b10, 16'h0018}) begin
      mismatched++;
      $display("[TB] FAIL simul_held: got %h expected %h", {alu_ready, mem_ready, busy}, {2'b10, 16'h0018});
    end
    @(negedge clk);
    compared++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 4'd3, 32'h11}) begin
      mismatched++;
      $display("[TB] FAIL simul_first_alu: got %h expected %h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 4'd3, 32'h11});
    end
    @(negedge clk);
    compared++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 4'd4, 32'h22}) begin
      mismatched++;
      $display("[TB] FAIL simul_second_mem: got %h expected %h", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 4'd4, 32'h22});
    end
    @(negedge clk);
    compared++;
    if (rf_wen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL simul_idle: got wen %b expected 0", rf_wen);
    end
  endtask

  task automatic test_age_order();
    logic        av [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  aa [7] = '{4'd2, 4'd3, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0};
    logic [31:0] ad [7] = '{32'h55, 32'h66, 32'h0, 32'hB, 32'h0, 32'h0, 32'h0};
    logic        mv [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [3:0]  ma [7] = '{4'd9, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [31:0] md [7] = '{32'h99, 32'h0, 32'hA, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [1:0]  expRdy [7] = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b11, 2'b11};
    logic [36:0] expRf [7] = '{37'h0, {1'b1, 4'd2, 32'h55}, {1'b1, 4'd9, 32'h99},
                               {1'b1, 4'd3, 32'h66}, {1'b1, 4'd7, 32'hA},
                               {1'b1, 4'd7, 32'hB}, {1'b0, 4'd7, 32'hB}};
    logic [15:0] expBusy [7] = '{16'h0204, 16'h020C, 16'h0288, 16'h0088, 16'h0080, 16'h0080, 16'h0000};
    do_reset();
    for (int c = 0; c < 7; c++) begin
      alu_valid = av[c]; alu_addr = aa[c]; alu_data = ad[c];
      mem_valid = mv[c]; mem_addr = ma[c]; mem_data = md[c];
      compared++;
      if ({alu_ready, mem_ready} !== expRdy[c]) begin
        mismatched++;
        $display("[TB] FAIL age_ready[%0d]: got %b expected %b", c, {alu_ready, mem_ready}, expRdy[c]);
      end
      @(negedge clk);
      compared++;
      if ({rf_wen, rf_waddr, rf_wdata, busy} !== {expRf[c], expBusy[c]}) begin
        mismatched++;
        $display("[TB] FAIL age_rf[%0d]: got %h expected %h", c, {rf_wen, rf_waddr, rf_wdata, busy},
                 {expRf[c], expBusy[c]});
      end
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_both_stream();
    int ai = 0;
    int mi = 0;
    logic ea;
    logic em;
    logic [36:0] expRf;
    do_reset();
    for (int k = 0; k < 20; k++) begin
      ea = (k == 0) ? 1'b1 : (k % 2 == 1);
      em = (k == 0) ? 1'b1 : (k % 2 == 0);
      compared++;
      if ({alu_ready, mem_ready} !== {ea, em}) begin
        mismatched++;
        $display("[TB] FAIL stream_ready[%0d]: got %b expected %b", k, {alu_ready, mem_ready}, {ea, em});
      end
      alu_valid = 1'b1; alu_addr = 4'(ai); alu_data = 32'hA000_0000 + 32'(ai);
      mem_valid = 1'b1; mem_addr = 4'(15 - mi); mem_data = 32'hB000_0000 + 32'(mi);
      @(negedge clk);
      if (ea) ai++;
      if (em) mi++;
      if (k == 0) expRf = 37'h0;
      else if (k % 2 == 1) expRf = {1'b1, 4'((k - 1) / 2), 32'hA000_0000 + 32'((k - 1) / 2)};
      else expRf = {1'b1, 4'(15 - (k - 2) / 2), 32'hB000_0000 + 32'((k - 2) / 2)};
      compared++;
      if ({rf_wen, rf_waddr, rf_wdata} !== expRf) begin
        mismatched++;
        $display("[TB] FAIL stream_rf[%0d]: got %h expected %h", k, {rf_wen, rf_waddr, rf_wdata}, expRf);
      end
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_mem_stream();
    logic [36:0] expRf;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        mem_valid = 1'b1; mem_addr = 4'(i); mem_data = 32'hC0 + 32'(i);
        compared++;
        if (mem_ready !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL memstream_ready[%0d]: got %b expected 1", i, mem_ready);
        end
      end else begin
        mem_valid = 1'b0;
      end
      @(negedge clk);
      if (i >= 1 && i <= 8) expRf = {1'b1, 4'(i - 1), 32'hC0 + 32'(i - 1)};
      else if (i == 0) expRf = 37'h0;
      else expRf = {1'b0, 4'd7, 32'hC7};
      compared++;
      if ({rf_wen, rf_waddr, rf_wdata} !== expRf) begin
        mismatched++;
        $display("[TB] FAIL memstream_rf[%0d]: got %h expected %h", i, {rf_wen, rf_waddr, rf_wdata}, expRf);
      end
    end
  endtask

  task automatic test_reset_mid_traffic();
    do_reset();
    alu_valid = 1'b1; alu_addr = 4'd1; alu_data = 32'h111;
    mem_valid = 1'b1; mem_addr = 4'd2; mem_data = 32'h222;
    @(negedge clk);
    alu_addr = 4'd6; alu_data = 32'h666;
    mem_valid = 1'b0;
    @(negedge clk);
    alu_valid = 1'b0;
    compared++;
    if ({rf_wen, rf_waddr, busy} !== {1'b1, 4'd1, 16'h0046}) begin
      mismatched++;
      $display("[TB] FAIL midrst_pre: got %h expected %h", {rf_wen, rf_waddr, busy}, {1'b1, 4'd1, 16'h0046});
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if ({rf_wen, busy, alu_ready, mem_ready} !== {1'b0, 16'h0000, 2'b11}) begin
      mismatched++;
      $display("[TB] FAIL midrst_async: got %h expected %h", {rf_wen, busy, alu_ready, mem_ready},
               {1'b0, 16'h0000, 2'b11});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compared++;
      if ({rf_wen, busy} !== 17'h0) begin
        mismatched++;
        $display("[TB] FAIL midrst_after[%0d]: got %h expected 0", i, {rf_wen, busy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_age_order();
    test_both_stream();
    test_mem_stream();
    test_reset_mid_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter for the 16x32 dual-read/single-write register file. It shares the file's single write port between two producers, the ALU and load/store units. Each producer gets a one-entry holding register, and the block issues at most one write per cycle in age order. It also exports a per-register pending-write scoreboard that the issue logic uses for RAW hazard stalls.

## Interface
- No parameters. Widths are fixed by the register file: 4-bit address, 32-bit data.
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU write-back request.
- alu_addr  in  4  destination register.
- alu_data  in  32  write data.
- alu_ready  out  1  ALU holding entry can accept this cycle.
- mem_valid  in  1  load write-back request.
- mem_addr  in  4  destination register.
- mem_data  in  32  write data.
- mem_ready  out  1  load holding entry can accept this cycle.
- rf_wen  out  1  register-file write enable (registered).
- rf_waddr  out  4  register-file write address (registered).
- rf_wdata  out  32  register-file write data (registered).
- busy  out  16  busy[r]=1 while any write to register r is held or driven on the RF port.

## Operation
- State:
  - Two holding entries, each with valid, addr, data.
  - Age bit `alu_older`.
  - Round-robin bit `last_mem`, which is 1 when the last grant went to mem.
  - Output registers rf_wen, rf_waddr and rf_wdata.
- Grant is combinational from the holding state only. It never depends on *_valid inputs.
  - Only one entry valid: grant that entry.
  - Both valid and they were loaded on different edges: grant the older one, per `alu_older`.
  - Both valid and loaded on the same edge: grant alu if last_mem=1, else mem.
- Ready:
  - alu_ready = !alu_hold_v | grant_alu.
  - mem_ready = !mem_hold_v | grant_mem.
  - Ready never depends on the same-cycle valid, so there is no combinational loop.
- Accept: on a posedge with valid&&ready, the entry loads addr and data and sets its valid bit.
  - If the entry is granted on the same edge, it drains and reloads on that edge.
- Drain: on each posedge, the granted entry is copied into the output registers with rf_wen=1, and its valid bit clears unless it reloads.
  - If nothing is granted, rf_wen=0, and rf_waddr and rf_wdata hold their last values.
- Age bit update:
  - An entry that loads while the other entry stays valid after this edge is the younger one.
  - Both loading on the same edge, with neither previously held, marks a tie. The tie is resolved by round-robin.
- last_mem updates on every grant: 1 if mem was granted, 0 if alu was granted.
- busy[r] is the OR of three terms: (alu_hold_v && alu_addr_q==r), (mem_hold_v && mem_addr_q==r), and (rf_wen && rf_waddr==r).
- Same-address writes from both producers are committed in acceptance order. The final RF value is the younger write.
- No address is special. Writes to register 0 are performed normally.

## Timing
- Reset, asynchronous: both holding valid bits are cleared, alu_older=0, last_mem=1, rf_wen=0, rf_waddr=0, rf_wdata=0, busy=0.
  - After reset, alu_ready=mem_ready=1.
  - Writes held or in flight when rst rises are discarded.
- Latency: a request accepted at posedge N appears on the rf_* outputs after posedge N+1 at the earliest. The register file captures it on the negedge inside cycle N+1.
- Throughput:
  - One RF write per cycle sustained.
  - A lone producer streaming with valid held high is accepted every cycle. Its entry drains and reloads on the same edge.
- Two producers streaming continuously:
  - Each producer accepts once every 2 cycles.
  - Grants alternate strictly.
  - Neither producer starves for more than 1 cycle.
- busy[r] asserts on the posedge after acceptance. It clears on the posedge after the cycle where rf_wen drove r, unless another write to r is pending.

## Test plan
- Reset mid-traffic:
  - Stimulus: both entries held, rf_wen=1, then rst asserted asynchronously between edges.
  - Response: rf_wen, busy and both valid bits clear immediately; readies return to 1; no RF write occurs after that point.
- Single ALU write:
  - Stimulus: alu_valid=1, addr=5, data=0xDEADBEEF at edge N.
  - Response: rf_wen=1, waddr=5, wdata=0xDEADBEEF after edge N+1; busy=0x0020 during cycles N+1 and N+2; busy=0 after edge N+2.
- Simultaneous first requests:
  - Stimulus: alu (addr 3, 0x11) and mem (addr 4, 0x22) both valid on the first edge after reset.
  - Response: alu writes first (last_mem=1), mem writes on the next cycle.
- Age order on the same address:
  - Stimulus: mem addr 7 = 0xA is accepted one edge before alu addr 7 = 0xB, while the mem entry is blocked behind an earlier alu write.
  - Response: the RF sees 0xA, then 0xB; the final value of r7 is 0xB.
- Both streaming for 20 cycles:
  - Response: rf_wen=1 on every cycle after the first; grants alternate alu, mem, alu…; each ready toggles with period 2.
- Lone mem stream:
  - Stimulus: mem_valid=1 for 8 consecutive cycles with addresses 0..7.
  - Response: mem_ready stays 1 throughout; the RF is written with registers 0..7 on 8 consecutive cycles.
